// File: rtl/matrix_chain_driver.sv
// Refresh engine for a cascade of MAX7219-compatible 8x8 matrix drivers.
// Define MATRIX_INTENSITY_PORT_EN to add a run-time intensity input.
module matrix_chain_driver #(
    parameter int         N_DEV     = 1,
    parameter int         CLK_DIV   = 4,
    parameter logic [3:0] INTENSITY = 4'h8,
    localparam int        AW        = (N_DEV * 8 > 8) ? $clog2(N_DEV * 8) : 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
`ifdef MATRIX_INTENSITY_PORT_EN
    input  logic [3:0]    intensity,
`endif
    output logic          sclk,
    output logic          cs_n,
    output logic          d
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    localparam int         FRAME_BITS = 16 * N_DEV;
    localparam logic [8:0] HALF_LAST  = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST   = 9'(2 * CLK_DIV - 1);
    localparam logic [7:0] BIT_LAST   = 8'(FRAME_BITS - 1);

    // Frame steps: 0..4 init, 5 refresh-time intensity, 6..13 rows 0..7.
    localparam logic [3:0] STEP_INIT_LAST = 4'd4;
    localparam logic [3:0] STEP_INT       = 4'd5;
    localparam logic [3:0] STEP_ROW0      = 4'd6;
    localparam logic [3:0] STEP_LAST      = 4'd13;
`ifdef MATRIX_INTENSITY_PORT_EN
    localparam logic [3:0] STEP_WARM      = STEP_INT;
`else
    localparam logic [3:0] STEP_WARM      = STEP_ROW0;
`endif

    state_t                  state;
    logic [8:0]              cnt;
    logic [7:0]              bit_cnt;
    logic [3:0]              step;
    logic                    init_done;
    logic [FRAME_BITS-1:0]   sr;
    logic [FRAME_BITS-1:0]   frame_word;
    logic [3:0]              next_step;
    logic [3:0]              int_q;
    logic [7:0]              fb [N_DEV*8];

`ifndef MATRIX_INTENSITY_PORT_EN
    assign int_q = INTENSITY;
`endif

    // NOTE: the frame buffer is plain storage with no reset, so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en && int'(wr_addr) < N_DEV * 8)
            fb[wr_addr] <= wr_data;
    end

`ifdef MATRIX_INTENSITY_PORT_EN
    assign next_step = step + 4'd1;
`else
    assign next_step = (step == STEP_INIT_LAST) ? STEP_ROW0 : step + 4'd1;
`endif

    // Device N_DEV-1 occupies the MSBs so it leaves the shifter first.
    logic [2:0]    row;
    logic [AW-1:0] rd_addr;
    logic [15:0]   dev_word;

    // NOTE: every always_comb output gets a default first so no latch can form.
    always_comb begin
        frame_word = '0;
        row        = 3'(step - STEP_ROW0);
        rd_addr    = '0;
        dev_word   = '0;
        for (int dev = 0; dev < N_DEV; dev++) begin
            rd_addr = AW'(dev * 8) + AW'(row);
            case (step)
                4'd0:           dev_word = 16'h0F00;
                4'd1:           dev_word = 16'h0900;
                4'd2:           dev_word = 16'h0B07;
                4'd3, STEP_INT: dev_word = {8'h0A, 4'h0, int_q};
                4'd4:           dev_word = 16'h0C01;
                default:        dev_word = {4'h0, {1'b0, row} + 4'd1, fb[rd_addr]};
            endcase
            frame_word[dev*16 +: 16] = dev_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            d         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            init_done <= 1'b0;
            cnt       <= '0;
            bit_cnt   <= '0;
            step      <= '0;
            sr        <= '0;
`ifdef MATRIX_INTENSITY_PORT_EN
            int_q     <= INTENSITY;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        cs_n  <= 1'b0;
                        cnt   <= '0;
                        step  <= init_done ? STEP_WARM : 4'd0;
                        state <= LOAD;
`ifdef MATRIX_INTENSITY_PORT_EN
                        int_q <= intensity;
`endif
                    end
                end

                // LOAD doubles as the first clk of the first sclk-low half.
                LOAD, SHIFT: begin
                    if (state == LOAD) begin
                        sr      <= frame_word;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                cs_n  <= 1'b1;
                                d     <= 1'b0;
                                state <= GAP;
                            end else begin
                                bit_cnt <= bit_cnt + 8'd1;
                                d       <= sr[FRAME_BITS-2];
                                sr      <= sr << 1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (step == STEP_INIT_LAST)
                            init_done <= 1'b1;
                        if (step == STEP_LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cs_n  <= 1'b0;
                            step  <= next_step;
                            state <= LOAD;
                        end
                    end else begin
                        cnt <= cnt + 9'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_chain_driver.sv
// Directed bench for matrix_chain_driver (N_DEV=2, CLK_DIV=2) with a frame scoreboard.
module tb_matrix_chain_driver;

    localparam int N_DEV     = 2;
    localparam int CLK_DIV   = 2;
    localparam int AW        = 4;
    localparam int FRAME_CYC = 32 * N_DEV * CLK_DIV + 2 * CLK_DIV;
`ifdef MATRIX_INTENSITY_PORT_EN
    localparam int         PORT  = 1;
    localparam logic [3:0] I_VAL = 4'h3;
`else
    localparam int         PORT  = 0;
    localparam logic [3:0] I_VAL = 4'h8;
`endif
    localparam int COLD_LAT = (13 + PORT) * FRAME_CYC;
    localparam int WARM_LAT = (8 + PORT) * FRAME_CYC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          busy, done, sclk, cs_n, d;
`ifdef MATRIX_INTENSITY_PORT_EN
    logic [3:0]    intensity = 4'h3;
`endif

    matrix_chain_driver #(.N_DEV(N_DEV), .CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
`ifdef MATRIX_INTENSITY_PORT_EN
        .intensity(intensity),
`endif
        .sclk     (sclk),
        .cs_n     (cs_n),
        .d        (d)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          frames_done = 0;
    int          n_done   = 0;
    int          exp_dones = 0;
    int          t0;
    logic [7:0]  mem [16];
    bit          model_init = 1'b0;
    logic [31:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard model ----------------
    task automatic push_word(input logic [15:0] w);
        exp_q.push_back({w, w});
    endtask

    task automatic push_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++)
            exp_q.push_back({4'h0, 4'(r + 1), mem[8 + r], 4'h0, 4'(r + 1), mem[r]});
    endtask

    task automatic push_refresh();
        if (!model_init) begin
            push_word(16'h0F00);
            push_word(16'h0900);
            push_word(16'h0B07);
            push_word({8'h0A, 4'h0, I_VAL});
            push_word(16'h0C01);
            model_init = 1'b1;
        end
        if (PORT != 0) push_word({8'h0A, 4'h0, I_VAL});
        push_rows(0, 7);
    endtask

    // ---------------- serial monitor ----------------
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_d = 1'b0;
    int          nbits = 0, low_cnt = 0, high_cnt = 0;
    bit          had_frame = 1'b0;
    logic [31:0] word = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            nbits     = 0;
            low_cnt   = 0;
            high_cnt  = 0;
            had_frame = 1'b0;
        end else begin
            if (done) begin
                n_done++;
                had_frame = 1'b0;
            end
            if (!cs_n) begin
                if (prev_cs) begin
                    if (had_frame) check("gap_len", high_cnt, 4);
                    nbits   = 0;
                    low_cnt = 0;
                    word    = '0;
                end
                low_cnt++;
                if (sclk && !prev_sclk) begin
                    word = {word[30:0], d};
                    nbits++;
                end
                if (sclk && prev_sclk) check("d_stable", d, prev_d);
            end else begin
                if (!prev_cs) begin
                    check("frame_len", low_cnt, 32 * N_DEV * CLK_DIV);
                    check("frame_bits", nbits, 16 * N_DEV);
                    check("sclk_idle", sclk, 1'b0);
                    check("sb_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("frame_word", word, exp_q.pop_front());
                    frames_done++;
                    had_frame = 1'b1;
                    high_cnt  = 0;
                end
                high_cnt++;
            end
            prev_cs   = cs_n;
            prev_sclk = sclk;
            prev_d    = d;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_byte(input int addr, input logic [7:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        mem[addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        exp_dones++;
    endtask

    task automatic wait_done(input int exp_lat, input bit extra_starts);
        int k = 0;
        while (!done && k < 5000) begin
            @(negedge clk);
            k++;
            start = (extra_starts && (k % 300 == 0));
        end
        start = 1'b0;
        check("latency", cyc - t0, exp_lat);
        repeat (10) @(negedge clk);
        check("busy_idle", busy, 1'b0);
        check("done_count", n_done, exp_dones);
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic wait_frames(input int target);
        int k = 0;
        while (frames_done < target && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("wait_frames", 32'(frames_done >= target), 1);
    endtask

    // ---------------- directed sequence ----------------
    int base;
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_sclk", sclk, 1'b0);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_d", d, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) write_byte(i, 8'(8'h10 + i));

        // Cold refresh: init frames then rows.
        push_refresh();
        kick();
        wait_done(COLD_LAT, 1'b0);

        // Warm refresh: rows only.
        push_refresh();
        kick();
        wait_done(WARM_LAT, 1'b0);

        // Starts while busy must be ignored.
        push_refresh();
        kick();
        wait_done(WARM_LAT, 1'b1);

        // Write to dev 1 row 7 while row 2 is on the wire.
        if (PORT != 0) push_word({8'h0A, 4'h0, I_VAL});
        push_rows(0, 2);
        base = frames_done;
        kick();
        wait_frames(base + PORT + 2);
        repeat (10) @(negedge clk);
        check("row2_active", cs_n, 1'b0);
        write_byte(15, 8'hAA);
        push_rows(3, 7);
        wait_done(WARM_LAT, 1'b0);

        // Reset in the middle of the fourth frame.
        push_refresh();
        base = frames_done;
        kick();
        wait_frames(base + 3);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cs_n", cs_n, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_sclk", sclk, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        model_init = 1'b0;
        exp_dones--;

        // Init must run again after the abort.
        push_refresh();
        kick();
        wait_done(COLD_LAT, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/matrix_chain_driver.md
MATRIX_CHAIN_DRIVER -- requirements
Module: matrix_chain_driver

Interface
REQ-001 SHALL have parameter N_DEV, default 1: number of cascaded 8x8 matrix driver devices (MAX7219-compatible), legal range 1..8.
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per sclk half-period, legal range 1..255.
REQ-003 SHALL have parameter INTENSITY, default 4'h8: intensity register value used when MATRIX_INTENSITY_PORT_EN is undefined.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle request to refresh the whole chain.
REQ-007 busy  output  1  high from accepted start until the refresh completes.
REQ-008 done  output  1  one-cycle pulse when the refresh completes.
REQ-009 wr_en  input  1  frame-buffer write strobe.
REQ-010 wr_addr  input  AW=$clog2(N_DEV*8), minimum 3  byte address = dev*8 + row; dev 0 is nearest the FPGA.
REQ-011 wr_data  input  8  row pattern, bit 7 = column 0.
REQ-012 sclk  output  1  serial clock to the chain.
REQ-013 cs_n  output  1  active-low load strobe to the chain.
REQ-014 d  output  1  serial data to the first device.

Function
REQ-015 SHALL store N_DEV*8 bytes; wr_en writes wr_data at wr_addr on the same edge; writes with wr_addr >= N_DEV*8 SHALL be ignored; writes are accepted at any time, including while busy.
REQ-016 A transfer word SHALL be {4'b0000, reg_addr[3:0], data[7:0]}, shifted MSB first.
REQ-017 A frame SHALL be one cs_n low period carrying 16*N_DEV bits, word for the farthest device (N_DEV-1) first and device 0 last.
REQ-018 In a frame, d SHALL change only while sclk is low; sclk high and sclk low each last CLK_DIV clk cycles; sclk SHALL idle low, so the frame is 32*N_DEV*CLK_DIV cycles.
REQ-019 After each frame, cs_n SHALL return high, with sclk low, for exactly 2*CLK_DIV cycles before the next frame or completion.
REQ-020 FSM states SHALL be IDLE, LOAD, SHIFT, GAP; start is accepted only in IDLE, is ignored while busy, and causes cs_n to fall on the next cycle.
REQ-021 When init_done is 0, the refresh SHALL first send 5 init frames, each with the same word for all devices: 0x0F00, 0x0900, 0x0B07, 0x0A0I (I = intensity), 0x0C01; init_done is then set.
REQ-022 Every refresh SHALL then send 8 row frames r = 0..7 with reg_addr = r+1; each device's data is the byte at dev*8 + r.
REQ-023 Row data SHALL be sampled at LOAD, the first cycle of each frame; a write that lands after that sample appears in the next refresh.
REQ-024 done SHALL pulse, and busy SHALL fall, in the cycle after the final GAP ends.
REQ-025 Refresh latency SHALL be 8*(32*N_DEV*CLK_DIV + 2*CLK_DIV) cycles, plus 5 more frames of the same length when init runs.

Reset
REQ-026 On rst: sclk=0, cs_n=1, d=0, busy=0, done=0, init_done=0, FSM=IDLE; frame-buffer contents are not reset.
REQ-027 A reset during a frame SHALL abort it; cs_n SHALL be high in the cycle after rst is sampled, and the next refresh SHALL re-run init.

Configuration
REQ-028 With MATRIX_INTENSITY_PORT_EN defined, a port intensity (input, 4 bits) SHALL exist; it is sampled at each refresh start and always sends the 0x0A0I frame, even when init_done=1 (6 frames before the rows).
REQ-029 With MATRIX_INTENSITY_PORT_EN undefined, there SHALL be no intensity port, I = INTENSITY, and the intensity frame is sent only during init.

Verification (N_DEV=2, CLK_DIV=2, macro undefined unless stated)
REQ-030 Reset, write bytes 0..15 = 0x10..0x1F, start -> 13 frames; frame 0 shifts 0x0F000F00; frame 5 shifts 0x01180110; 1716 cycles from start to done.
REQ-031 Second start after done -> 8 frames only; done follows 1056 cycles after start; cs_n low for exactly 128 cycles per frame and high for 4 cycles between frames.
REQ-032 Start pulses while busy -> ignored; exactly one done pulse per accepted start.
REQ-033 Write 0xAA to addr 15 during row 2 of a refresh -> row 7 of device 1 sends 0xAA in the same refresh; write to addr 16 -> no buffer change.
REQ-034 Assert rst mid-frame 3 -> cs_n=1 on the next cycle, busy=0; the next start re-sends the 5 init frames.
REQ-035 Macro defined, intensity=4'h3 -> every refresh sends 0x0A030A03, and a refresh without init takes 1188 cycles.
